reg_file: RTL and testbench

//  - 32 x 32-bit RISC-V integer register file for the single-cycle core; directly upstream of the ALU.
//  - RD1 drives ALU SrcA; RD2 drives the SrcB mux and store data; WD3 is the writeback result (ALUResult/load/PC+4).
//  - Two asynchronous read ports, one synchronous write port; x0 reads as zero, writes to it are discarded.

---
 rtl/riscv_pkg.sv | 15 +
 rtl/reg_file_if.sv | 21 ++
 rtl/rf_read_port.sv | 47 ++++
 rtl/reg_file.sv | 52 +++++
 tb/tb_reg_file.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: architectural constants and types shared across the core.
//  - XLEN       : integer register / datapath width
//  - REG_ADDR_W : register specifier width (rs1/rs2/rd)
//  - NUM_REGS   : number of architectural integer registers (2**REG_ADDR_W)
//  - REG_ZERO   : the hard-wired zero register x0
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: bundle of the register-file access signals.
//  - A1/A2  : read addresses (rs1/rs2), RD1/RD2 : read data, combinational
//  - A3/WD3/WE3 : write address, data and enable, captured on the rising clock
// Timing contract: there is no valid/ready handshake. Reads are pure
// combinational lookups; a write is a one-cycle command that takes effect at
// the rising edge on which WE3 is sampled high.
// Modports: master = core datapath (drives addresses/write), slave = reg_file.
interface reg_file_if;
  import riscv_pkg::*;

  reg_addr_t A1;
  reg_addr_t A2;
  reg_addr_t A3;
  word_t     WD3;
  logic      WE3;
  word_t     RD1;
  word_t     RD2;

  modport master (output A1, A2, A3, WD3, WE3, input RD1, RD2);
  modport slave  (input A1, A2, A3, WD3, WE3, output RD1, RD2);
endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the integer register file.
//  - addr      : register to read; x0 is forced to zero
//  - regs      : stored registers x1..x(NREGS-1)
//  - reset, we, wa, wd : current-cycle write command, used only for forwarding
//  - rd        : read data
// Macro REGFILE_BYPASS_EN: when defined, a write to the same register in the
// same cycle is forwarded to rd (suppressed during reset). When undefined the
// port returns the stored value, so read-during-write sees the old data.
module rf_read_port #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NUM_REGS,
  parameter int AW    = riscv_pkg::REG_ADDR_W
) (
  input  logic            reset,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [1:NREGS-1],
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd = '0;
    if (addr != '0) begin
      rd = regs[addr];
      // wa==addr and addr!=0 together imply the write is not to x0.
      if (!reset && we && (wa == addr)) begin
        rd = wd;
      end
    end
  end
`else
  always_comb begin
    rd = '0;
    if (addr != '0) begin
      rd = regs[addr];
    end
  end

  // Write-side inputs exist only to keep one port list for both builds.
  logic unused_bypass;
  assign unused_bypass = &{1'b0, reset, we, wa, wd};
`endif

endmodule

// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit RISC-V integer register file, 2 async reads, 1 sync write.
//  - clk   : core clock, all updates on rising edge
//  - reset : synchronous active-high; clears x1..x31 and wins over a write
//  - bus   : reg_file_if slave (A1/A2 -> RD1/RD2, A3/WD3/WE3 write)
// x0 has no storage; it always reads 0 and writes to it are dropped.
// Macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding in the
// read ports; the storage and write path are the same in both builds.
// The interface carries riscv_pkg widths, so XLEN/AW must stay at the
// package values when the interface is used.
module reg_file #(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NUM_REGS,
  parameter int AW    = riscv_pkg::REG_ADDR_W
) (
  input  logic       clk,
  input  logic       reset,
  reg_file_if.slave  bus
);

  logic [XLEN-1:0] regs [1:NREGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.WE3 && (bus.A3 != '0)) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  rf_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd1 (
    .reset (reset),
    .addr  (bus.A1),
    .regs  (regs),
    .we    (bus.WE3),
    .wa    (bus.A3),
    .wd    (bus.WD3),
    .rd    (bus.RD1)
  );

  rf_read_port #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_rd2 (
    .reset (reset),
    .addr  (bus.A2),
    .regs  (regs),
    .we    (bus.WE3),
    .wa    (bus.A3),
    .wd    (bus.WD3),
    .rd    (bus.RD2)
  );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file (both builds, follows
// REGFILE_BYPASS_EN). Reference model: a plain array of 32 words updated by
// the architectural write rule, read through the architectural read rule.
module tb_reg_file;
  import riscv_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_file_if rf_bus ();

  reg_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_bus.slave)
  );

  // ---------------- reference model + scoreboard ----------------
  word_t model [NUM_REGS];
  logic [XLEN-1:0] exp_q [$];
  int vectors;
  int miscompares;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Expected read value for address a given the command currently driven.
  function automatic word_t ref_read(input reg_addr_t a);
    if (a == 0) return '0;
    if (BYPASS && !reset && rf_bus.WE3 && rf_bus.A3 == a) return rf_bus.WD3;
    return model[a];
  endfunction

  // Apply the architectural effect of the rising edge to the model.
  function automatic void ref_edge();
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (rf_bus.WE3 && rf_bus.A3 != 0) begin
      model[rf_bus.A3] = rf_bus.WD3;
    end
  endfunction

  task automatic check(input string tag, input word_t got, input word_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic we, input reg_addr_t a3,
                       input word_t wd, input reg_addr_t a1, input reg_addr_t a2);
    reset      = rst;
    rf_bus.WE3 = we;
    rf_bus.A3  = a3;
    rf_bus.WD3 = wd;
    rf_bus.A1  = a1;
    rf_bus.A2  = a2;
    #1;
  endtask

  // Compare both read ports against the model for the inputs now driven.
  task automatic check_reads(input string tag);
    exp_q.push_back(ref_read(rf_bus.A1));
    exp_q.push_back(ref_read(rf_bus.A2));
    check({tag, "_rd1"}, rf_bus.RD1, exp_q.pop_front());
    check({tag, "_rd2"}, rf_bus.RD2, exp_q.pop_front());
  endtask

  // Clock edge: model follows the command held across the edge.
  task automatic tick();
    @(posedge clk);
    ref_edge();
    #1;
  endtask

  task automatic write_reg(input reg_addr_t a, input word_t d);
    drive(1'b0, 1'b1, a, d, '0, '0);
    tick();
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < NUM_REGS; i++) begin
      drive(1'b0, 1'b0, '0, '0, reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i));
      check_reads(tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    @(posedge clk);
    #1;

    // Reset held 2 cycles with a competing write to x5.
    drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, '0, '0);
    tick();
    tick();
    sweep("reset");

    // x0 protection.
    write_reg(5'd0, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, '0, '0, 5'd0, 5'd0);
    check("x0_rd1", rf_bus.RD1, 32'h0);
    sweep("x0_others");

    // Write/read boundary values at both ends of the file.
    write_reg(5'd1, 32'h7FFFFFFF);
    write_reg(5'd31, 32'h80000000);
    drive(1'b0, 1'b0, '0, '0, 5'd1, 5'd31);
    check("wr_x1", rf_bus.RD1, 32'h7FFFFFFF);
    check("wr_x31", rf_bus.RD2, 32'h80000000);
    drive(1'b0, 1'b0, '0, '0, 5'd31, 5'd31);
    check("same_rd1", rf_bus.RD1, 32'h80000000);
    check("same_rd2", rf_bus.RD2, 32'h80000000);

    // Read during write.
    write_reg(5'd7, 32'h11111111);
    drive(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd0);
    check("rdw_before", rf_bus.RD1, BYPASS ? 32'h22222222 : 32'h11111111);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd7, 5'd0);
    check("rdw_after", rf_bus.RD1, 32'h22222222);

    // Reset mid-operation beats a write; bypass is suppressed under reset.
    write_reg(5'd3, 32'hAAAAAAAA);
    drive(1'b1, 1'b1, 5'd3, 32'h55555555, 5'd3, 5'd3);
    check("rst_mid_before", rf_bus.RD1, 32'hAAAAAAAA);
    tick();
    drive(1'b0, 1'b0, '0, '0, 5'd3, 5'd7);
    check("rst_mid_x3", rf_bus.RD1, 32'h0);
    check("rst_mid_x7", rf_bus.RD2, 32'h0);

    // Random traffic with reset pulses at cycles 100 and 350.
    for (int cyc = 0; cyc < 500; cyc++) begin
      reg_addr_t a1, a2, a3;
      a1 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      a2 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      a3 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      // Steer some writes onto a read address to exercise read-during-write.
      if ($urandom_range(0, 3) == 0) a3 = a1;
      else if ($urandom_range(0, 3) == 0) a3 = a2;
      drive((cyc == 100) || (cyc == 350), 1'($urandom_range(0, 1)), a3,
            word_t'($urandom), a1, a2);
      check_reads("rand");
      tick();
    end

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
